// File: rtl/pitch_pkg.sv
// Shared types, defaults and helper functions for the pitch tracker.
// Optional smoothing is enabled with PITCH_SMOOTH_EN (see pitch_tracker.sv).
package pitch_pkg;

    typedef enum logic [1:0] {FILL, START, SCAN, UPDATE} state_t;

    localparam int DEF_SAMPLE_W       = 12;
    localparam int DEF_KEEP_BITS      = 8;
    localparam int DEF_DATA_W         = 16;
    localparam int DEF_FFT_N          = 64;
    localparam int DEF_MAG_W          = 32;
    localparam int DEF_DECIM          = 50000;
    localparam int DEF_MIN_BIN        = 1;
    localparam int DEF_MIN_MAG        = 1024;
    localparam int DEF_HEIGHT_W       = 10;
    localparam int DEF_HEIGHT_SCALE   = 5;
    localparam int DEF_HEIGHT_OFFSET  = 16;
    localparam int DEF_HEIGHT_DEFAULT = 50;

    // Keep the top keep_bits of the sample, left-justified in data_w.
    function automatic logic [63:0] format_sample(
        input logic [63:0] mic,
        input int          sample_w,
        input int          keep_bits,
        input int          data_w
    );
        logic [63:0] kept;
        kept = (mic >> (sample_w - keep_bits)) &
               ((64'd1 << keep_bits) - 64'd1);
        return kept << (data_w - keep_bits);
    endfunction

    // Height for a bin, computed at hw+8 bits and saturated to hw bits.
    function automatic logic [31:0] bin_to_height(
        input logic [31:0] k,
        input logic        silent,
        input int          hw,
        input int          scale,
        input int          offset,
        input int          dflt
    );
        logic [63:0] t;
        logic [63:0] top;
        t   = silent ? 64'(dflt) : 64'(offset) + 64'(scale) * 64'(k);
        t   = t & ((64'd1 << (hw + 8)) - 64'd1);
        top = (64'd1 << hw) - 64'd1;
        return 32'((t > top) ? top : t);
    endfunction

endpackage

// File: rtl/pitch_argmax.sv
// Serial strict-greater argmax over a bin stream.
// Bins below win_start are skipped; ties keep the lowest index.
module pitch_argmax
    import pitch_pkg::*;
#(
    parameter int N     = DEF_FFT_N,
    parameter int MAG_W = DEF_MAG_W,
    parameter int K_W   = $clog2(DEF_FFT_N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid,
    input  logic             last,
    input  logic [K_W-1:0]   win_start,
    input  logic [MAG_W-1:0] mag,
    output logic [K_W-1:0]   best_k,
    output logic [MAG_W-1:0] best_mag,
    output logic             done
);

    logic [K_W-1:0] k;

    assign done = valid && (last || k == K_W'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            k        <= '0;
            best_k   <= '0;
            best_mag <= '0;
        end else if (valid) begin
            if (k >= win_start && mag > best_mag) begin
                best_k   <= k;
                best_mag <= mag;
            end
            k <= k + K_W'(1);
        end
    end

endmodule

// File: rtl/pitch_tracker.sv
// Mic decimation, FFT frame capture, bin argmax and height mapping.
// Define PITCH_SMOOTH_EN to average each new height with the previous one.
module pitch_tracker
    import pitch_pkg::*;
#(
    parameter int SAMPLE_W       = DEF_SAMPLE_W,
    parameter int KEEP_BITS      = DEF_KEEP_BITS,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int FFT_N          = DEF_FFT_N,
    parameter int MAG_W          = DEF_MAG_W,
    parameter int DECIM          = DEF_DECIM,
    parameter int MIN_BIN        = DEF_MIN_BIN,
    parameter int MIN_MAG        = DEF_MIN_MAG,
    parameter int HEIGHT_W       = DEF_HEIGHT_W,
    parameter int HEIGHT_SCALE   = DEF_HEIGHT_SCALE,
    parameter int HEIGHT_OFFSET  = DEF_HEIGHT_OFFSET,
    parameter int HEIGHT_DEFAULT = DEF_HEIGHT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [SAMPLE_W-1:0]     mic_data,
    output logic [FFT_N*DATA_W-1:0] fft_frame,
    output logic                    fft_start,
    input  logic                    bin_valid,
    input  logic [MAG_W-1:0]        bin_mag,
    input  logic                    bin_last,
    output logic [HEIGHT_W-1:0]     height,
    output logic                    height_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int K_W     = $clog2(FFT_N);
    localparam int CNT_W   = $clog2(FFT_N + 1);
    localparam int T_W     = $clog2(DECIM);
    localparam int FRAME_W = FFT_N * DATA_W;

    localparam logic [HEIGHT_W-1:0] H_RST = HEIGHT_W'(bin_to_height(
        32'd0, 1'b1, HEIGHT_W, HEIGHT_SCALE, HEIGHT_OFFSET, HEIGHT_DEFAULT));

    state_t               state;
    state_t               state_d;
    logic [T_W-1:0]       tick_cnt;
    logic                 tick;
    logic [DATA_W-1:0]    sample;
    logic [FRAME_W-1:0]   shift_q;
    logic [FRAME_W-1:0]   shift_next;
    logic [CNT_W-1:0]     new_cnt;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 full;
    logic [K_W-1:0]       best_k;
    logic [MAG_W-1:0]     best_mag;
    logic                 scan_done;
    logic                 silent;
    logic [HEIGHT_W-1:0]  target;
    logic [HEIGHT_W-1:0]  height_d;

    assign tick   = tick_cnt == T_W'(DECIM - 1);
    assign sample = DATA_W'(format_sample(
        64'(mic_data), SAMPLE_W, KEEP_BITS, DATA_W));

    assign shift_next = tick ? {shift_q[FRAME_W-DATA_W-1:0], sample}
                             : shift_q;
    assign full    = new_cnt == CNT_W'(FFT_N);
    assign cnt_inc = (tick && !full) ? new_cnt + CNT_W'(1) : new_cnt;

    assign fft_start = state == START;
    assign busy      = state != FILL;

    pitch_argmax #(
        .N     (FFT_N),
        .MAG_W (MAG_W),
        .K_W   (K_W)
    ) u_argmax (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == START),
        .valid     (bin_valid && state == SCAN),
        .last      (bin_last),
        .win_start (K_W'(MIN_BIN)),
        .mag       (bin_mag),
        .best_k    (best_k),
        .best_mag  (best_mag),
        .done      (scan_done)
    );

    assign silent = best_mag < MAG_W'(MIN_MAG);
    assign target = HEIGHT_W'(bin_to_height(32'(best_k), silent, HEIGHT_W,
        HEIGHT_SCALE, HEIGHT_OFFSET, HEIGHT_DEFAULT));

`ifdef PITCH_SMOOTH_EN
    logic [HEIGHT_W:0] sum;
    assign sum      = {1'b0, height} + {1'b0, target};
    assign height_d = HEIGHT_W'(sum >> 1);
`else
    assign height_d = target;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            FILL:    if (full) state_d = START;
            START:   state_d = SCAN;
            SCAN:    if (scan_done) state_d = UPDATE;
            UPDATE:  state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt     <= '0;
            shift_q      <= '0;
            new_cnt      <= '0;
            fft_frame    <= '0;
            height       <= H_RST;
            height_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            tick_cnt     <= tick ? '0 : tick_cnt + T_W'(1);
            shift_q      <= shift_next;
            height_valid <= 1'b0;
            // A sample arriving with the snapshot is kept and counted.
            if (state == FILL && full) begin
                fft_frame <= shift_next;
                new_cnt   <= tick ? CNT_W'(1) : '0;
            end else begin
                new_cnt <= cnt_inc;
            end
            if (state != FILL && full) begin
                overrun <= 1'b1;
            end
            if (state == UPDATE) begin
                height       <= height_d;
                height_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pitch_tracker.sv
// Directed bench for pitch_tracker: DECIM=4, FFT_N=8, MIN_MAG=64.
// A second instance with HEIGHT_W=5 runs in lockstep for saturation.
module tb_pitch_tracker;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [11:0]  mic = 12'hAB5;
    logic         bin_valid = 1'b0;
    logic         bin_last = 1'b0;
    logic [31:0]  bin_mag = '0;

    logic [127:0] fft_frame;
    logic         fft_start;
    logic [9:0]   height;
    logic         height_valid;
    logic         busy;
    logic         overrun;

    logic [127:0] frame_s;
    logic         start_s;
    logic [4:0]   height_s;
    logic         hv_s;
    logic         busy_s;
    logic         ovr_s;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pitch_tracker #(
        .DECIM   (4),
        .FFT_N   (8),
        .MIN_MAG (64)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .mic_data     (mic),
        .fft_frame    (fft_frame),
        .fft_start    (fft_start),
        .bin_valid    (bin_valid),
        .bin_mag      (bin_mag),
        .bin_last     (bin_last),
        .height       (height),
        .height_valid (height_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    pitch_tracker #(
        .DECIM          (4),
        .FFT_N          (8),
        .MIN_MAG        (64),
        .HEIGHT_W       (5),
        .HEIGHT_DEFAULT (20)
    ) u_sat (
        .clk          (clk),
        .reset        (reset),
        .mic_data     (mic),
        .fft_frame    (frame_s),
        .fft_start    (start_s),
        .bin_valid    (bin_valid),
        .bin_mag      (bin_mag),
        .bin_last     (bin_last),
        .height       (height_s),
        .height_valid (hv_s),
        .busy         (busy_s),
        .overrun      (ovr_s)
    );

    task automatic wait_start(output int n, output bit saw_hv);
        n = -1;
        saw_hv = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (height_valid) saw_hv = 1'b1;
            if (fft_start) begin
                n = c + 1;
                break;
            end
        end
    endtask

    task automatic drive_frame(
        input  bit          do_wait,
        input  logic [31:0] mags [8],
        input  int          last_idx,
        output bit          ok,
        output logic        fs1,
        output logic        hv1,
        output logic        hv2,
        output logic        hv3,
        output logic        fs3,
        output logic [9:0]  h,
        output logic [4:0]  hs
    );
        int  n;
        bit  saw;
        ok = 1'b1;
        {fs1, hv1, hv2, hv3, fs3} = '1;
        h = '1;
        hs = '1;
        if (do_wait) begin
            wait_start(n, saw);
            ok = n > 0;
        end
        if (!ok) return;
        @(negedge clk);
        fs1 = fft_start;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            bin_valid = 1'b1;
            bin_mag = mags[i];
            bin_last = (i == last_idx);
            if (i == last_idx) break;
        end
        @(negedge clk);
        bin_valid = 1'b0;
        bin_last = 1'b0;
        bin_mag = '0;
        hv1 = height_valid;
        @(negedge clk);
        hv2 = height_valid;
        h = height;
        hs = height_s;
        @(negedge clk);
        hv3 = height_valid;
        fs3 = fft_start;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (height !== 10'd50) begin
            n_fail++;
            $display("FAIL reset_height got %0d want 50", height);
        end
        n_checks++;
        if (height_s !== 5'd20) begin
            n_fail++;
            $display("FAIL reset_height_sat got %0d want 20", height_s);
        end
        n_checks++;
        if ({height_valid, fft_start, busy, overrun} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000",
                     {height_valid, fft_start, busy, overrun});
        end
        n_checks++;
        if (fft_frame !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_frame got %h want 0", fft_frame);
        end
        reset = 1'b0;
    endtask

    task automatic test_frame_fill();
        int   n;
        bit   saw;
        logic [127:0] exp_frame = {8{16'hAB00}};
        wait_start(n, saw);
        n_checks++;
        if (n != 33) begin
            n_fail++;
            $display("FAIL fill_start_cycle got %0d want 33", n);
        end
        n_checks++;
        if (fft_frame !== exp_frame) begin
            n_fail++;
            $display("FAIL fill_frame got %h want %h", fft_frame, exp_frame);
        end
        n_checks++;
        if (busy !== 1'b1 || saw) begin
            n_fail++;
            $display("FAIL fill_busy got busy=%b hv=%b want 1/0", busy, saw);
        end
    endtask

    task automatic test_argmax();
        logic [31:0] m [8];
        bit ok;
        logic fs1, hv1, hv2, hv3, fs3;
        logic [9:0] h;
        logic [4:0] hs;
        m = '{9999, 100, 5, 900, 3, 0, 0, 0};
        drive_frame(1'b0, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if ({fs1, hv1, hv2, hv3} !== 4'b0010) begin
            n_fail++;
            $display("FAIL argmax_pulses got %b want 0010",
                     {fs1, hv1, hv2, hv3});
        end
        n_checks++;
        if (h !== 10'd31) begin
            n_fail++;
            $display("FAIL argmax_height got %0d want 31", h);
        end
        n_checks++;
        if (hs !== 5'd31) begin
            n_fail++;
            $display("FAIL argmax_height_sat got %0d want 31", hs);
        end
    endtask

    task automatic test_silence_and_tie();
        logic [31:0] m [8];
        bit ok;
        logic fs1, hv1, hv2, hv3, fs3;
        logic [9:0] h;
        logic [4:0] hs;
        m = '{5000, 63, 10, 63, 0, 1, 2, 63};
        drive_frame(1'b1, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (!ok || h !== 10'd50 || hv2 !== 1'b1) begin
            n_fail++;
            $display("FAIL silence_height got %0d hv=%b want 50 hv=1", h, hv2);
        end
        n_checks++;
        if (hs !== 5'd20) begin
            n_fail++;
            $display("FAIL silence_height_sat got %0d want 20", hs);
        end
        m = '{100, 100, 900, 100, 100, 900, 100, 100};
        drive_frame(1'b1, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (!ok || h !== 10'd26) begin
            n_fail++;
            $display("FAIL tie_height got %0d want 26", h);
        end
    endtask

    task automatic test_saturate_and_early_last();
        logic [31:0] m [8];
        bit ok;
        logic fs1, hv1, hv2, hv3, fs3;
        logic [9:0] h;
        logic [4:0] hs;
        m = '{0, 70, 80, 90, 100, 110, 120, 5000};
        drive_frame(1'b1, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (!ok || h !== 10'd51) begin
            n_fail++;
            $display("FAIL sat_main_height got %0d want 51", h);
        end
        n_checks++;
        if (hs !== 5'd31) begin
            n_fail++;
            $display("FAIL sat_small_height got %0d want 31", hs);
        end
        m = '{0, 200, 0, 0, 300, 9000, 9000, 9000};
        drive_frame(1'b1, m, 4, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (!ok || h !== 10'd36) begin
            n_fail++;
            $display("FAIL early_last_height got %0d want 36", h);
        end
        n_checks++;
        if ({hv1, hv2, hv3} !== 3'b010) begin
            n_fail++;
            $display("FAIL early_last_pulse got %b want 010", {hv1, hv2, hv3});
        end
    endtask

    task automatic test_overrun();
        logic [31:0] m [8];
        int n;
        bit saw;
        bit ok;
        logic fs1, hv1, hv2, hv3, fs3;
        logic [9:0] h;
        logic [4:0] hs;
        wait_start(n, saw);
        n_checks++;
        if (n < 0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_pre got n=%0d ovr=%b want n>0 ovr=0",
                     n, overrun);
        end
        repeat (40) @(negedge clk);
        n_checks++;
        if ({overrun, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL overrun_set got %b want 11", {overrun, busy});
        end
        m = '{0, 2000, 0, 0, 0, 0, 0, 0};
        drive_frame(1'b0, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (h !== 10'd21 || hv2 !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_height got %0d hv=%b want 21 hv=1", h, hv2);
        end
        n_checks++;
        if (fs3 !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_restart got %b want 1", fs3);
        end
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky got %b want 1", overrun);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] m [8];
        int n;
        bit saw;
        bit ok;
        logic fs1, hv1, hv2, hv3, fs3;
        logic [9:0] h;
        logic [4:0] hs;
        logic [127:0] exp_frame = {8{16'h3F00}};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            bin_valid = 1'b1;
            bin_mag = 32'd7000;
        end
        @(negedge clk);
        bin_valid = 1'b0;
        reset = 1'b1;
        mic = 12'h3FF;
        @(negedge clk);
        n_checks++;
        if (height !== 10'd50 || height_s !== 5'd20) begin
            n_fail++;
            $display("FAIL midscan_height got %0d/%0d want 50/20",
                     height, height_s);
        end
        n_checks++;
        if ({height_valid, busy, overrun, fft_start} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midscan_flags got %b want 0000",
                     {height_valid, busy, overrun, fft_start});
        end
        reset = 1'b0;
        wait_start(n, saw);
        n_checks++;
        if (n != 33 || saw) begin
            n_fail++;
            $display("FAIL midscan_restart got n=%0d hv=%b want 33/0", n, saw);
        end
        n_checks++;
        if (fft_frame !== exp_frame) begin
            n_fail++;
            $display("FAIL midscan_frame got %h want %h", fft_frame, exp_frame);
        end
        m = '{0, 64, 63, 63, 64, 0, 0, 0};
        drive_frame(1'b0, m, 7, ok, fs1, hv1, hv2, hv3, fs3, h, hs);
        n_checks++;
        if (h !== 10'd21 || hv2 !== 1'b1) begin
            n_fail++;
            $display("FAIL min_mag_edge got %0d hv=%b want 21 hv=1", h, hv2);
        end
    endtask

    initial begin
        test_reset();
        test_frame_fill();
        test_argmax();
        test_silence_and_tie();
        test_saturate_and_early_last();
        test_overrun();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
